sram_seq: RTL and testbench

Memory access sequencer directly upstream of the SRAM mapping stage. It arbitrates between the video fetch port and the CPU port, translates the quasi-disk (kvaz) configuration into a per-access `ramdisk_page`, and sequences address, data and `memwr_n` strobes with setup, strobe and hold phases. It captures `din` at the end of the strobe and returns it to the winning requester with a one-cycle ack.

---
 rtl/sram_seq_pkg.sv | 22 ++
 rtl/kvaz_page_decode.sv | 25 ++
 rtl/sram_seq.sv | 133 +++++++++++++
 tb/tb_sram_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared encodings and constants for the SRAM access sequencer and its
// quasi-disk (kvaz) page decode.
package sram_seq_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  localparam int unsigned StackEnBit = 4;
  localparam int unsigned WinEnBit   = 5;
  localparam int unsigned StackPgLsb = 0;
  localparam int unsigned WinPgLsb   = 2;

  localparam logic [15:0] WinLo = 16'hA000;
  localparam logic [15:0] WinHi = 16'hDFFF;

  localparam logic [1:0] VidBurstLimit = 2'd2;

  // Quasi-disk pages are numbered from 1; page 0 is main RAM.
  function automatic logic [2:0] kvaz_page(input logic [1:0] pg);
    return {1'b0, pg} + 3'd1;
  endfunction

endpackage

// File: rtl/kvaz_page_decode.sv
// Combinational quasi-disk page selection from the config register, the
// stack flag and the byte address.
module kvaz_page_decode
  import sram_seq_pkg::*;
(
  input  logic [7:0]  cfg,
  input  logic        stack,
  input  logic [15:0] addr,
  output logic [2:0]  page
);

  logic in_win;

  assign in_win = (addr >= WinLo) && (addr <= WinHi);

  always_comb begin
    page = 3'd0;
    if (cfg[StackEnBit] && stack) begin
      page = kvaz_page(cfg[StackPgLsb +: 2]);
    end else if (cfg[WinEnBit] && in_win) begin
      page = kvaz_page(cfg[WinPgLsb +: 2]);
    end
  end

endmodule

// File: rtl/sram_seq.sv
// Arbitrates video and CPU requests and sequences setup/strobe/hold phases
// towards the SRAM mapper, returning read data with a one-cycle ack.
module sram_seq
  import sram_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_stack,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_data,
  output logic [7:0]  cfg_q,
  output logic [15:0] abus,
  output logic [7:0]  dout,
  output logic        memwr_n,
  output logic [2:0]  ramdisk_page,
  input  logic [7:0]  din
);

  localparam logic [2:0] LastStrobe = 3'(STROBE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] strb_q, strb_d;
  logic [1:0] burst_q, burst_d;
  logic       we_q;
  logic       id_cpu_q;
  logic       grant_vid, grant_cpu;
  logic [2:0] cpu_page;
  logic       strobe_last;

  kvaz_page_decode u_cpu_page (
    .cfg   (cfg_q),
    .stack (cpu_stack),
    .addr  (cpu_addr),
    .page  (cpu_page)
  );

  assign strobe_last = (state_q == StStrobe) && (strb_q == LastStrobe);

  always_comb begin
    state_d   = state_q;
    strb_d    = strb_q;
    burst_d   = burst_q;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Video normally wins, but a starved CPU gets one turn after the burst limit.
        if (vid_req && !(cpu_req && (burst_q >= VidBurstLimit))) begin
          grant_vid = 1'b1;
          burst_d   = cpu_req ? burst_q + 2'd1 : 2'd0;
          state_d   = StSetup;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          burst_d   = 2'd0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        strb_d  = 3'd0;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (strb_q == LastStrobe) begin
          state_d = StHold;
        end else begin
          strb_d = strb_q + 3'd1;
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      state_q      <= StIdle;
      strb_q       <= 3'd0;
      burst_q      <= 2'd0;
      we_q         <= 1'b0;
      id_cpu_q     <= 1'b0;
      abus         <= 16'd0;
      dout         <= 8'd0;
      ramdisk_page <= 3'd0;
      cfg_q        <= 8'd0;
      vid_rdata    <= 8'd0;
      cpu_rdata    <= 8'd0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      burst_q <= burst_d;
      if (cfg_we) begin
        cfg_q <= cfg_data;
      end
      if (grant_vid) begin
        abus         <= vid_addr;
        dout         <= 8'd0;
        we_q         <= 1'b0;
        id_cpu_q     <= 1'b0;
        ramdisk_page <= 3'd0;
      end else if (grant_cpu) begin
        abus         <= cpu_addr;
        dout         <= cpu_wdata;
        we_q         <= cpu_we;
        id_cpu_q     <= 1'b1;
        ramdisk_page <= cpu_page;
      end
      if (strobe_last && !we_q) begin
        if (id_cpu_q) begin
          cpu_rdata <= din;
        end else begin
          vid_rdata <= din;
        end
      end
    end
  end

  assign memwr_n = !((state_q == StStrobe) && we_q);
  assign vid_ack = (state_q == StHold) && !id_cpu_q;
  assign cpu_ack = (state_q == StHold) && id_cpu_q;

endmodule

// File: tb/tb_sram_seq.sv
// Directed self-checking bench for sram_seq: timing, page decode, arbitration,
// config update during an access and reset mid-write.
module tb_sram_seq;

  localparam int N = 2;

  logic        clk24 = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_stack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cfg_we;
  logic [7:0]  cfg_data;
  logic [7:0]  cfg_q;
  logic [15:0] abus;
  logic [7:0]  dout;
  logic        memwr_n;
  logic [2:0]  ramdisk_page;
  logic [7:0]  din;

  int checks = 0;
  int errors = 0;

  sram_seq #(.STROBE_CYCLES(N)) dut (
    .clk24        (clk24),
    .reset        (reset),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_rdata    (vid_rdata),
    .vid_ack      (vid_ack),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_stack    (cpu_stack),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cfg_we       (cfg_we),
    .cfg_data     (cfg_data),
    .cfg_q        (cfg_q),
    .abus         (abus),
    .dout         (dout),
    .memwr_n      (memwr_n),
    .ramdisk_page (ramdisk_page),
    .din          (din)
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memwr_n"}, 32'(memwr_n), 32'd1);
    check({tag, "_abus"}, 32'(abus), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_page"}, 32'(ramdisk_page), 32'd0);
    check({tag, "_cfg"}, 32'(cfg_q), 32'd0);
    check({tag, "_acks"}, 32'({vid_ack, cpu_ack}), 32'd0);
    check({tag, "_rdata"}, 32'({vid_rdata, cpu_rdata}), 32'd0);
  endtask

  // One CPU access starting from an idle negedge; k counts negedges after the grant edge.
  task automatic cpu_xfer(input logic we, input logic stack, input logic [15:0] addr,
                          input logic [7:0] wdata, input int cfg_k, input logic [7:0] cfg_val,
                          output int ack_k, output int low_cnt, output int first_low,
                          output logic addr_ok, output logic [2:0] pg, output logic pg_ok,
                          output logic [7:0] dout_s, output logic [7:0] rd);
    @(negedge clk24);
    cpu_we = we; cpu_stack = stack; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    ack_k = 0; low_cnt = 0; first_low = 0; addr_ok = 1'b1; pg_ok = 1'b1;
    pg = 3'd0; dout_s = 8'd0; rd = 8'd0;
    for (int k = 1; k <= 12 && ack_k == 0; k++) begin
      @(negedge clk24);
      cfg_we = 1'b0;
      if (k == 1) pg = ramdisk_page;
      if (abus !== addr) addr_ok = 1'b0;
      if (ramdisk_page !== pg) pg_ok = 1'b0;
      if (memwr_n === 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = k;
        dout_s = dout;
      end
      if (k == cfg_k) begin
        cfg_we = 1'b1;
        cfg_data = cfg_val;
      end
      if (cpu_ack === 1'b1) begin
        ack_k = k;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
  endtask

  int          ack_k, low_cnt, first_low;
  logic        addr_ok, pg_ok;
  logic [2:0]  pg;
  logic [7:0]  dout_s, rd;
  int          n_ack;
  logic        order [6];
  logic        both_ack;
  int          vid_low;
  logic        vid_addr_ok, vid_pg_ok;
  logic [7:0]  vid_rd, cpu_rd_seen;
  int          vid_k;
  logic        late_ack;

  initial begin
    reset = 1'b1; vid_req = 1'b0; vid_addr = 16'd0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_stack = 1'b0; cpu_addr = 16'd0; cpu_wdata = 8'd0; cfg_we = 1'b0; cfg_data = 8'd0;
    din = 8'd0;
    repeat (3) @(negedge clk24);
    check_reset_outputs("reset");
    reset = 1'b0;

    // CPU write 0x5A to 0x1234, cfg 0
    cpu_xfer(1'b1, 1'b0, 16'h1234, 8'h5A, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("wr_ack_cycle", 32'(ack_k), 32'(N + 2));
    check("wr_low_count", 32'(low_cnt), 32'(N));
    check("wr_first_low", 32'(first_low), 32'd2);
    check("wr_abus_stable", 32'(addr_ok), 32'd1);
    check("wr_dout", 32'(dout_s), 32'h5A);
    check("wr_page", 32'(pg), 32'd0);

    // Config 0x3D: stack page 2, window page 4
    @(negedge clk24);
    cfg_we = 1'b1; cfg_data = 8'h3D;
    @(negedge clk24);
    cfg_we = 1'b0;
    check("cfg_q", 32'(cfg_q), 32'h3D);

    din = 8'h3C;
    cpu_xfer(1'b0, 1'b0, 16'hB000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_win_page", 32'(pg), 32'd4);
    check("rd_win_data", 32'(rd), 32'h3C);
    check("rd_no_strobe", 32'(low_cnt), 32'd0);
    check("rd_ack_cycle", 32'(ack_k), 32'(N + 2));

    din = 8'h4B;
    cpu_xfer(1'b0, 1'b1, 16'hB000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_stack_page", 32'(pg), 32'd2);
    check("rd_stack_data", 32'(rd), 32'h4B);

    cpu_xfer(1'b0, 1'b0, 16'h4000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_main_page", 32'(pg), 32'd0);
    cpu_xfer(1'b0, 1'b0, 16'hA000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_win_lo", 32'(pg), 32'd4);
    cpu_xfer(1'b0, 1'b0, 16'hDFFF, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_win_hi", 32'(pg), 32'd4);
    cpu_xfer(1'b0, 1'b0, 16'h9FFF, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_below_win", 32'(pg), 32'd0);
    cpu_xfer(1'b0, 1'b0, 16'hE000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("rd_above_win", 32'(pg), 32'd0);

    // Both requesters held: expect V,V,C,V,V,C
    @(negedge clk24);
    din = 8'h11; vid_addr = 16'h0100; cpu_addr = 16'h2000; cpu_we = 1'b0; cpu_stack = 1'b0;
    vid_req = 1'b1; cpu_req = 1'b1;
    n_ack = 0; both_ack = 1'b0;
    for (int c = 0; c < 60 && n_ack < 6; c++) begin
      @(negedge clk24);
      if (vid_ack && cpu_ack) both_ack = 1'b1;
      if (vid_ack) begin order[n_ack] = 1'b0; n_ack++; end
      else if (cpu_ack) begin order[n_ack] = 1'b1; n_ack++; end
      if (n_ack == 6) begin vid_req = 1'b0; cpu_req = 1'b0; end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("arb_ack_count", 32'(n_ack), 32'd6);
    check("arb_no_double", 32'(both_ack), 32'd0);
    check("arb_order", 32'({order[0], order[1], order[2], order[3], order[4], order[5]}),
          32'b001001);

    // cfg write during STROBE of a window write: old page kept, next access sees new page
    cpu_xfer(1'b1, 1'b0, 16'hC000, 8'h99, 2, 8'h29, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("cfgmid_page", 32'(pg), 32'd4);
    check("cfgmid_page_held", 32'(pg_ok), 32'd1);
    check("cfgmid_cfg_q", 32'(cfg_q), 32'h29);
    din = 8'h66;
    cpu_xfer(1'b0, 1'b0, 16'hC000, 8'h00, 0, 8'h00, ack_k, low_cnt, first_low, addr_ok, pg,
             pg_ok, dout_s, rd);
    check("cfgnew_page", 32'(pg), 32'd3);
    check("cfgnew_data", 32'(rd), 32'h66);

    // Video read in the window: page 0, data to vid_rdata only
    @(negedge clk24);
    din = 8'hA7; vid_addr = 16'hB123; vid_req = 1'b1;
    vid_k = 0; vid_low = 0; vid_addr_ok = 1'b1; vid_pg_ok = 1'b1; vid_rd = 8'd0;
    cpu_rd_seen = 8'd0;
    for (int k = 1; k <= 12 && vid_k == 0; k++) begin
      @(negedge clk24);
      if (abus !== 16'hB123) vid_addr_ok = 1'b0;
      if (ramdisk_page !== 3'd0) vid_pg_ok = 1'b0;
      if (memwr_n === 1'b0) vid_low++;
      if (vid_ack === 1'b1) begin
        vid_k = k; vid_rd = vid_rdata; cpu_rd_seen = cpu_rdata; vid_req = 1'b0;
      end
    end
    check("vid_ack_cycle", 32'(vid_k), 32'(N + 2));
    check("vid_rdata", 32'(vid_rd), 32'hA7);
    check("vid_cpu_rdata_kept", 32'(cpu_rd_seen), 32'h66);
    check("vid_abus", 32'(vid_addr_ok), 32'd1);
    check("vid_page0", 32'(vid_pg_ok), 32'd1);
    check("vid_no_strobe", 32'(vid_low), 32'd0);

    // Reset during STROBE of a write
    @(negedge clk24);
    @(negedge clk24);
    cpu_we = 1'b1; cpu_stack = 1'b0; cpu_addr = 16'hD000; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(negedge clk24);
    @(negedge clk24);
    check("rst_mid_strobe_low", 32'(memwr_n), 32'd0);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk24);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    late_ack = 1'b0;
    repeat (N + 3) begin
      @(negedge clk24);
      if (vid_ack || cpu_ack || !memwr_n) late_ack = 1'b1;
    end
    check("rst_mid_no_ack", 32'(late_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
